// File: rtl/fpga_bram_master.sv
// Initiator for the multiplexed address/data BRAM bus: one request at a time, sequenced as
// enable pulse, address phase, optional write-data phase, then a bounded wait for the reply.
// Define FPGA_BRAM_MASTER_RETRY_EN to replay the bus sequence once after a first timeout.
module fpga_bram_master #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_we_i,
  input  logic [ADDRESS_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0]    req_wdata_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [DATA_WIDTH-1:0]    rsp_rdata_o,
  output logic                     rsp_error_o,
  output logic                     read_en_o,
  output logic                     write_en_o,
  output logic                     address_on_o,
  output logic                     data_on_o,
  output logic [DATA_WIDTH-1:0]    address_data_bus_o,
  input  logic                     resp_valid_i,
  input  logic [DATA_WIDTH-1:0]    address_data_bus_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ENABLE = 3'd1,
    ADDR   = 3'd2,
    DATA   = 3'd3,
    WAIT   = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t                   state_q;
  logic                     we_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [CNT_W-1:0]         cnt_d;
  logic                     timeout_s;
  logic                     req_ready_q;
  logic                     rsp_valid_q;
  logic [DATA_WIDTH-1:0]    rsp_rdata_q;
  logic                     rsp_error_q;
  logic                     read_en_q;
  logic                     write_en_q;
  logic                     address_on_q;
  logic                     data_on_q;
  logic [DATA_WIDTH-1:0]    bus_q;
`ifdef FPGA_BRAM_MASTER_RETRY_EN
  logic                     retry_q;
`endif

  // WAIT-cycle counter increment and final-timeout-cycle detection
  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1);
    timeout_s = (cnt_q == TO_LAST);
  end

  // Transaction FSM; every output is registered from the transition being taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_error_q  <= 1'b0;
      read_en_q    <= 1'b0;
      write_en_q   <= 1'b0;
      address_on_q <= 1'b0;
      data_on_q    <= 1'b0;
      bus_q        <= '0;
`ifdef FPGA_BRAM_MASTER_RETRY_EN
      retry_q      <= 1'b0;
`endif
    end else begin
      // Bus strobes are single-cycle unless a transition below re-asserts them
      read_en_q    <= 1'b0;
      write_en_q   <= 1'b0;
      address_on_q <= 1'b0;
      data_on_q    <= 1'b0;
      bus_q        <= '0;
      case (state_q)
        IDLE: begin
`ifdef FPGA_BRAM_MASTER_RETRY_EN
          retry_q <= 1'b0;
`endif
          if (req_valid_i && req_ready_q) begin
            we_q        <= req_we_i;
            addr_q      <= req_addr_i;
            wdata_q     <= req_wdata_i;
            req_ready_q <= 1'b0;
            read_en_q   <= !req_we_i;
            write_en_q  <= req_we_i;
            state_q     <= ENABLE;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        ENABLE: begin
          address_on_q <= 1'b1;
          bus_q        <= DATA_WIDTH'(addr_q);
          state_q      <= ADDR;
        end
        ADDR: begin
          cnt_q <= '0;
          if (we_q) begin
            data_on_q <= 1'b1;
            bus_q     <= wdata_q;
            state_q   <= DATA;
          end else begin
            state_q   <= WAIT;
          end
        end
        DATA: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // A reply on the final timeout cycle still wins over the timeout
          if (resp_valid_i) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= we_q ? '0 : address_data_bus_i;
            rsp_error_q <= 1'b0;
            state_q     <= RESP;
          end else if (timeout_s) begin
`ifdef FPGA_BRAM_MASTER_RETRY_EN
            if (!retry_q) begin
              retry_q    <= 1'b1;
              read_en_q  <= !we_q;
              write_en_q <= we_q;
              state_q    <= ENABLE;
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= '0;
              rsp_error_q <= 1'b1;
              state_q     <= RESP;
            end
`else
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b1;
            state_q     <= RESP;
`endif
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            rsp_valid_q <= 1'b1;
          end
        end
        default: begin
          req_ready_q <= 1'b0;
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready_o        = req_ready_q;
  assign rsp_valid_o        = rsp_valid_q;
  assign rsp_rdata_o        = rsp_rdata_q;
  assign rsp_error_o        = rsp_error_q;
  assign read_en_o          = read_en_q;
  assign write_en_o         = write_en_q;
  assign address_on_o       = address_on_q;
  assign data_on_o          = data_on_q;
  assign address_data_bus_o = bus_q;

endmodule

// File: tb/tb_fpga_bram_master.sv
// Self-checking bench for fpga_bram_master (TIMEOUT_CYCLES = 4); expected responses go
// through a scoreboard queue. Timing index n counts negedges after the accepting edge T.
module tb_fpga_bram_master;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid_i, req_ready_o, req_we_i;
  logic [AW-1:0] req_addr_i;
  logic [DW-1:0] req_wdata_i;
  logic          rsp_valid_o, rsp_ready_i, rsp_error_o;
  logic [DW-1:0] rsp_rdata_o;
  logic          read_en_o, write_en_o, address_on_o, data_on_o;
  logic [DW-1:0] address_data_bus_o;
  logic          resp_valid_i;
  logic [DW-1:0] address_data_bus_i;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;
  exp_t exp_q[$];

  fpga_bram_master #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_error_o(rsp_error_o),
    .read_en_o(read_en_o), .write_en_o(write_en_o),
    .address_on_o(address_on_o), .data_on_o(data_on_o),
    .address_data_bus_o(address_data_bus_o),
    .resp_valid_i(resp_valid_i), .address_data_bus_i(address_data_bus_i)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Waits (bounded) for req_ready_o, presents one request for one edge; returns at n=1.
  task automatic start_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (req_ready_o === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = a; req_wdata_i = d;
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  // Responder model: replies at index reply_n (-1 = never) and runs until rsp_valid_o.
  task automatic run_bus(input int n0, input int reply_n, input logic [DW-1:0] rd,
                         output int n_rsp, output int pulses, output int viol);
    int n = n0;
    n_rsp = -1; pulses = 0; viol = 0;
    while (n < n0 + 40 && n_rsp < 0) begin
      if (rsp_valid_o === 1'b1) begin
        n_rsp = n;
      end else begin
        if (read_en_o || write_en_o) pulses++;
        if ($countones({read_en_o, write_en_o, address_on_o, data_on_o}) > 1 ||
            (!address_on_o && !data_on_o && address_data_bus_o != '0)) viol++;
        resp_valid_i       = (n == reply_n);
        address_data_bus_i = (n == reply_n) ? rd : 64'hBAD0_BAD0_BAD0_BAD0;
        @(negedge clk);
        n++;
      end
    end
    resp_valid_i = 1'b0;
  endtask

  task automatic handshake();
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
    rsp_ready_i = 1'b0; resp_valid_i = 1'b0; address_data_bus_i = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready_o, rsp_valid_o, rsp_error_o, read_en_o, write_en_o, address_on_o, data_on_o} !== 7'b0 ||
        rsp_rdata_o !== 64'h0 || address_data_bus_o !== 64'h0) begin
      errors++;
      $display("FAIL reset_outputs: ctl=%b rdata=%h bus=%h want all zero",
               {req_ready_o, rsp_valid_o, rsp_error_o, read_en_o, write_en_o, address_on_o, data_on_o},
               rsp_rdata_o, address_data_bus_o);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++; $display("FAIL idle_ready: got %b want 1", req_ready_o);
    end
  endtask

  task automatic test_read();
    bit ok; int n_rsp, pulses, viol; exp_t e;
    start_req(1'b0, 32'h0000_1000, 64'h0, ok);
    exp_q.push_back('{rdata: 64'hDEAD_BEEF_0123_4567, err: 1'b0});
    checks++;
    if (!ok || read_en_o !== 1'b1 || write_en_o !== 1'b0) begin
      errors++; $display("FAIL read_enable: ok=%0d rd=%b wr=%b want 1 1 0", ok, read_en_o, write_en_o);
    end
    @(negedge clk);
    checks++;
    if (address_on_o !== 1'b1 || read_en_o !== 1'b0 || address_data_bus_o !== 64'h0000_0000_0000_1000) begin
      errors++; $display("FAIL read_addr: on=%b bus=%h want 1 0000000000001000", address_on_o, address_data_bus_o);
    end
    @(negedge clk);
    run_bus(3, 5, 64'hDEAD_BEEF_0123_4567, n_rsp, pulses, viol);
    checks++;
    if (n_rsp != 6 || pulses != 0 || viol != 0) begin
      errors++; $display("FAIL read_latency: n=%0d pulses=%0d viol=%0d want 6 0 0", n_rsp, pulses, viol);
    end
    e = exp_q.pop_front();
    checks++;
    if (rsp_rdata_o !== e.rdata || rsp_error_o !== e.err) begin
      errors++; $display("FAIL read_rsp: got %h/%b want %h/%b", rsp_rdata_o, rsp_error_o, e.rdata, e.err);
    end
    handshake();
    checks++;
    if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      errors++; $display("FAIL read_done: valid=%b ready=%b want 0 1", rsp_valid_o, req_ready_o);
    end
  endtask

  task automatic test_write();
    bit ok; int n_rsp, pulses, viol; exp_t e;
    start_req(1'b1, 32'h0000_0040, 64'hA5A5_A5A5_A5A5_A5A5, ok);
    exp_q.push_back('{rdata: 64'h0, err: 1'b0});
    checks++;
    if (!ok || write_en_o !== 1'b1 || read_en_o !== 1'b0) begin
      errors++; $display("FAIL write_enable: ok=%0d wr=%b rd=%b want 1 1 0", ok, write_en_o, read_en_o);
    end
    @(negedge clk);
    checks++;
    if (address_on_o !== 1'b1 || address_data_bus_o !== 64'h40) begin
      errors++; $display("FAIL write_addr: on=%b bus=%h want 1 40", address_on_o, address_data_bus_o);
    end
    @(negedge clk);
    checks++;
    if (data_on_o !== 1'b1 || address_on_o !== 1'b0 || address_data_bus_o !== 64'hA5A5_A5A5_A5A5_A5A5) begin
      errors++; $display("FAIL write_data: on=%b bus=%h want 1 a5a5a5a5a5a5a5a5", data_on_o, address_data_bus_o);
    end
    @(negedge clk);
    run_bus(4, 4, 64'h1234_5678_9ABC_DEF0, n_rsp, pulses, viol);
    checks++;
    if (n_rsp != 5 || pulses != 0 || viol != 0) begin
      errors++; $display("FAIL write_latency: n=%0d pulses=%0d viol=%0d want 5 0 0", n_rsp, pulses, viol);
    end
    e = exp_q.pop_front();
    checks++;
    if (rsp_rdata_o !== e.rdata || rsp_error_o !== e.err) begin
      errors++; $display("FAIL write_rsp: got %h/%b want %h/%b", rsp_rdata_o, rsp_error_o, e.rdata, e.err);
    end
    handshake();
  endtask

  task automatic test_timeout();
    bit ok; int n_rsp, pulses, viol; exp_t e;
    int exp_n, exp_p;
`ifdef FPGA_BRAM_MASTER_RETRY_EN
    exp_n = 13; exp_p = 1;
`else
    exp_n = 7;  exp_p = 0;
`endif
    start_req(1'b0, 32'h0000_2000, 64'h0, ok);
    exp_q.push_back('{rdata: 64'h0, err: 1'b1});
    @(negedge clk);
    run_bus(2, -1, 64'h0, n_rsp, pulses, viol);
    checks++;
    if (!ok || n_rsp != exp_n || pulses != exp_p || viol != 0) begin
      errors++; $display("FAIL timeout_latency: ok=%0d n=%0d pulses=%0d viol=%0d want 1 %0d %0d 0",
                         ok, n_rsp, pulses, viol, exp_n, exp_p);
    end
    e = exp_q.pop_front();
    checks++;
    if (rsp_rdata_o !== e.rdata || rsp_error_o !== e.err) begin
      errors++; $display("FAIL timeout_rsp: got %h/%b want %h/%b", rsp_rdata_o, rsp_error_o, e.rdata, e.err);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    bit ok; int n_rsp, pulses, viol; exp_t e;
    start_req(1'b0, 32'h0000_3000, 64'h0, ok);
    exp_q.push_back('{rdata: 64'hCAFE_F00D_5555_AAAA, err: 1'b0});
    run_bus(1, 3, 64'hCAFE_F00D_5555_AAAA, n_rsp, pulses, viol);
    checks++;
    if (!ok || n_rsp != 4 || pulses != 1 || viol != 0) begin
      errors++; $display("FAIL bp_latency: ok=%0d n=%0d pulses=%0d viol=%0d want 1 4 1 0", ok, n_rsp, pulses, viol);
    end
    e = exp_q.pop_front();
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h0000_0BAD;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== e.rdata || rsp_error_o !== e.err ||
          req_ready_o !== 1'b0 || read_en_o !== 1'b0 || write_en_o !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d: valid=%b data=%h err=%b ready=%b en=%b%b want 1 %h %b 0 00",
                           i, rsp_valid_o, rsp_rdata_o, rsp_error_o, req_ready_o, read_en_o, write_en_o,
                           e.rdata, e.err);
      end
    end
    req_valid_i = 1'b0;
    handshake();
    checks++;
    if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || write_en_o !== 1'b0) begin
      errors++; $display("FAIL bp_done: valid=%b ready=%b wr=%b want 0 1 0", rsp_valid_o, req_ready_o, write_en_o);
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int n_rsp, pulses, viol, seen; exp_t e;
    start_req(1'b0, 32'h0000_5000, 64'h0, ok);
    @(negedge clk);
    checks++;
    if (!ok || address_on_o !== 1'b1) begin
      errors++; $display("FAIL mid_addr: ok=%0d on=%b want 1 1", ok, address_on_o);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready_o, rsp_valid_o, read_en_o, write_en_o, address_on_o, data_on_o} !== 6'b0 ||
        address_data_bus_o !== 64'h0) begin
      errors++; $display("FAIL mid_reset: ctl=%b bus=%h want 0 0",
                         {req_ready_o, rsp_valid_o, read_en_o, write_en_o, address_on_o, data_on_o},
                         address_data_bus_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    resp_valid_i = 1'b1; address_data_bus_i = 64'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid_o === 1'b1) seen++;
    end
    resp_valid_i = 1'b0;
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL mid_no_rsp: got %0d response cycles want 0", seen);
    end
    start_req(1'b0, 32'h0000_6000, 64'h0, ok);
    exp_q.push_back('{rdata: 64'h1111_2222_3333_4444, err: 1'b0});
    run_bus(1, 3, 64'h1111_2222_3333_4444, n_rsp, pulses, viol);
    e = exp_q.pop_front();
    checks++;
    if (!ok || n_rsp != 4 || rsp_rdata_o !== e.rdata || rsp_error_o !== e.err) begin
      errors++; $display("FAIL mid_recover: ok=%0d n=%0d got %h/%b want 4 %h/%b",
                         ok, n_rsp, rsp_rdata_o, rsp_error_o, e.rdata, e.err);
    end
    handshake();
  endtask

  task automatic test_spurious();
    bit ok; int n_rsp, pulses, viol; exp_t e;
    start_req(1'b0, 32'h0000_7000, 64'h0, ok);
    exp_q.push_back('{rdata: 64'h7777_8888_9999_0000, err: 1'b0});
    @(negedge clk);
    resp_valid_i = 1'b1; address_data_bus_i = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    run_bus(3, 3 + TO - 1, 64'h7777_8888_9999_0000, n_rsp, pulses, viol);
    checks++;
    if (!ok || n_rsp != 3 + TO || viol != 0) begin
      errors++; $display("FAIL spurious_latency: ok=%0d n=%0d viol=%0d want 1 %0d 0", ok, n_rsp, viol, 3 + TO);
    end
    e = exp_q.pop_front();
    checks++;
    if (rsp_rdata_o !== e.rdata || rsp_error_o !== e.err) begin
      errors++; $display("FAIL spurious_rsp: got %h/%b want %h/%b", rsp_rdata_o, rsp_error_o, e.rdata, e.err);
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_spurious();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
